// File: rtl/candy_defines.v
// Shared SRAM bus widths for the candy memory subsystem.
// Each width is guarded so a testbench or another unit may pre-define the same
// value without triggering a redefinition.
`ifndef SRAMAddrWidth
`define SRAMAddrWidth 16
`endif
`ifndef SRAMDataWidth
`define SRAMDataWidth 32
`endif

// File: rtl/candy_mem_ctrl.sv
// candy_mem_ctrl: bridges a valid/ready CPU request/response channel onto a
// single-port SRAM interface with a separate write port and read port. Exactly
// one transaction is in flight at a time. The controller detects a read that
// never completes and returns an error response for it.
//
// Ports
//   clk_i            system clock; all state changes occur on the rising edge
//   rst_i            asynchronous reset, active low (rst_i == 0 resets)
//   req_valid_i      CPU request present
//   req_ready_o      controller accepts a request this cycle (IDLE only)
//   req_we_i         1 = write, 0 = read
//   req_addr_i       request address
//   req_wdata_i      write data
//   resp_valid_o     response available
//   resp_ready_i     CPU consumes the response
//   resp_rdata_o     read data; 0 for writes and for timed-out reads
//   resp_err_o       1 = the read timed out
//   write_enable_o   SRAM write strobe (one cycle per write)
//   waddr_o/wdata_o  SRAM write address and data (captured request values)
//   read_enable_o    SRAM read strobe (one cycle per read)
//   raddr_o          SRAM read address (captured request address)
//   rdata_i          SRAM read data
//   rdata_ready_i    one-cycle pulse from the SRAM marking rdata_i valid
//
// Parameter
//   TIMEOUT          number of READ_WAIT cycles without rdata_ready_i before an
//                    error response is returned; legal range 2..255
`include "candy_defines.v"

module candy_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [`SRAMAddrWidth-1:0] req_addr_i,
    input  logic [`SRAMDataWidth-1:0] req_wdata_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [`SRAMDataWidth-1:0] resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      write_enable_o,
    output logic [`SRAMAddrWidth-1:0] waddr_o,
    output logic [`SRAMDataWidth-1:0] wdata_o,
    output logic                      read_enable_o,
    output logic [`SRAMAddrWidth-1:0] raddr_o,
    input  logic [`SRAMDataWidth-1:0] rdata_i,
    input  logic                      rdata_ready_i
);

    // Last counter value that still belongs to a legal wait; TIMEOUT is at most
    // 255, so an 8-bit counter always suffices.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        RESP
    } state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [`SRAMAddrWidth-1:0]   addr_q, addr_d;
    logic [`SRAMDataWidth-1:0]   wdata_q, wdata_d;
    logic [`SRAMDataWidth-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        req_ready_q;
    logic                        accept;

    // The request handshake is qualified by the registered ready flag. That
    // flag is low while reset is held and for the cycle after release, so no
    // request can be accepted before the first clock edge outside reset.
    assign accept = req_valid_i && req_ready_q;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // The captured write flag is held by the branch taken
                    // here. No separate we register is needed.
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = req_we_i ? WRITE : READ_REQ;
                end
            end
            WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            READ_REQ: begin
                cnt_d   = '0;
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                if (rdata_ready_i) begin
                    rdata_d = rdata_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // TIMEOUT consecutive wait cycles have passed with no data.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every flop, including the datapath registers, is cleared by the
    // asynchronous reset. This keeps the SRAM address and data outputs at 0
    // until the first request is accepted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // values from before the edge, whatever order these lines are in.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            // Registered copy of "next state is IDLE". The RESP cycle that
            // completes the handshake therefore still shows ready low.
            req_ready_q <= (state_d == IDLE);
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = (state_q == RESP);
    assign resp_rdata_o   = rdata_q;
    assign resp_err_o     = err_q;
    assign write_enable_o = (state_q == WRITE);
    assign read_enable_o  = (state_q == READ_REQ);
    assign waddr_o        = addr_q;
    assign wdata_o        = wdata_q;
    assign raddr_o        = addr_q;

endmodule
